alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational datapath ALU.
- Registers its result and produces status flags (Z/N/C/V).
- Adds shift operations and an iterative shift-add multiplier.
- Sits between decode/operand-fetch and writeback; valid/ready on both sides, so the multiplier can stall the pipeline.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_seq_mul.sv | 74 +++++++
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - ALU_OP_*   : 4-bit opcode encodings presented on in_op
//   - FLAG_*     : bit positions inside the 4-bit {V,C,N,Z} flag vector
//   - state_t    : controller FSM state encodings
package alu_seq_pkg;

    localparam logic [3:0] ALU_OP_THA = 4'd0;
    localparam logic [3:0] ALU_OP_THB = 4'd1;
    localparam logic [3:0] ALU_OP_ADD = 4'd2;
    localparam logic [3:0] ALU_OP_SUB = 4'd3;
    localparam logic [3:0] ALU_OP_MUL = 4'd4;
    localparam logic [3:0] ALU_OP_AND = 4'd5;
    localparam logic [3:0] ALU_OP_ORR = 4'd6;
    localparam logic [3:0] ALU_OP_XOR = 4'd7;
    localparam logic [3:0] ALU_OP_SHL = 4'd8;
    localparam logic [3:0] ALU_OP_SHR = 4'd9;
    localparam logic [3:0] ALU_OP_SRA = 4'd10;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative LSB-first shift-add multiplier.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load operands a/b and begin WIDTH iterations
//   a, b       : unsigned operands (sampled on start)
//   done       : high during the cycle whose edge performs the last iteration
//   product    : full 2*WIDTH product, valid while done is high
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [SHW-1:0]     cnt_r;
    logic               busy_r;
    logic [2*WIDTH-1:0] acc_next_s;

    // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // The final product is exposed from the combinational next value so the
    // parent can register it on the same edge as the last iteration.
    assign done    = busy_r && (cnt_r == SHW'(WIDTH - 1));
    assign product = acc_next_s;

    // Iteration state: operand load on start, one shift-add step per cycle while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= '0;
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + SHW'(1);
            busy_r   <= !done;
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
            busy_r   <= busy_r;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with status flags and iterative multiply.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : operand handshake; in_op, in_a, in_b carry the request
//   out_valid/out_ready  : result handshake; out_result, out_flags {V,C,N,Z}, out_err
// Single-cycle ops are computed combinationally and registered on accept;
// MUL is delegated to alu_seq_mul and stalls the input side until it finishes.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [3:0]        out_flags,
    output logic              out_err
);

    localparam int SHW = $clog2(WIDTH);

    state_t               state_r;
    logic                 accept_s;
    logic                 is_mul_s;
    logic [WIDTH+4:0]     alu_s;
    logic                 mul_done_s;
    logic [2*WIDTH-1:0]   mul_product_s;
    logic [3:0]           mul_flags_s;

    // Single-cycle operations; returns {err, flags[3:0], result}.
    function automatic logic [WIDTH+4:0] alu_compute(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] res;
        logic [SHW-1:0]   sh;
        logic [3:0]       f;
        logic             c;
        logic             v;
        logic             err;
        sh   = b[SHW-1:0];
        wide = '0;
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        err  = 1'b0;
        f    = 4'b0000;
        case (op)
            ALU_OP_THA: res = a;
            ALU_OP_THB: res = b;
            ALU_OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[WIDTH-1:0];
                c    = wide[WIDTH];
                v    = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                res = a - b;
                c   = (a < b);
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_OP_MUL: res = '0;
            ALU_OP_AND: res = a & b;
            ALU_OP_ORR: res = a | b;
            ALU_OP_XOR: res = a ^ b;
            ALU_OP_SHL: res = a << sh;
            ALU_OP_SHR: res = a >> sh;
            ALU_OP_SRA: res = $unsigned($signed(a) >>> sh);
            default:    err = 1'b1;
        endcase
        // Illegal opcodes report all-zero flags, including Z.
        if (!err) begin
            f[FLAG_Z] = (res == '0);
            f[FLAG_N] = res[WIDTH-1];
            f[FLAG_C] = c;
            f[FLAG_V] = v;
        end else begin
            f = 4'b0000;
        end
        return {err, f, res};
    endfunction

    // in_ready: open in IDLE, pass-through of out_ready in HOLD, closed in MUL and under reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (state_r == ST_IDLE) begin
            in_ready = 1'b1;
        end else if (state_r == ST_HOLD) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b0;
        end
    end

    assign accept_s  = in_valid && in_ready;
    assign is_mul_s  = (in_op == ALU_OP_MUL);
    assign alu_s     = alu_compute(in_op, in_a, in_b);
    assign out_valid = (state_r == ST_HOLD);

    // MUL flags: C reports a non-zero high product half; V is never set.
    always_comb begin
        mul_flags_s         = 4'b0000;
        mul_flags_s[FLAG_Z] = (mul_product_s[WIDTH-1:0] == '0);
        mul_flags_s[FLAG_N] = mul_product_s[WIDTH-1];
        mul_flags_s[FLAG_C] = (mul_product_s[2*WIDTH-1:WIDTH] != '0);
        mul_flags_s[FLAG_V] = 1'b0;
    end

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_s && is_mul_s),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Controller FSM and registered result/flag/error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            out_result <= '0;
            out_flags  <= 4'b0000;
            out_err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s) begin
                        if (is_mul_s) begin
                            state_r <= ST_MUL;
                            out_err <= 1'b0;
                        end else begin
                            state_r    <= ST_HOLD;
                            out_result <= alu_s[WIDTH-1:0];
                            out_flags  <= alu_s[WIDTH+3:WIDTH];
                            out_err    <= alu_s[WIDTH+4];
                        end
                    end else if ((state_r == ST_HOLD) && out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_r    <= ST_HOLD;
                        out_result <= mul_product_s[WIDTH-1:0];
                        out_flags  <= mul_flags_s;
                        out_err    <= 1'b0;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        out_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for exactly one edge (caller ensures in_ready is 1).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Take the held result and return to IDLE.
    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %0b want 0", in_ready);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_result !== 32'h0) $display("FAIL reset_out_result: got %h want 0", out_result);
        else pass_cnt++;
        total_cnt++;
        if (out_flags !== 4'b0000 || out_err !== 1'b0)
            $display("FAIL reset_flags_err: got flags=%b err=%b want 0000/0", out_flags, out_err);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_release: got %0b want 1", in_ready);
        else pass_cnt++;
    endtask

    // Each single-cycle vector: result and flags one edge after accept.
    task automatic test_single(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
        issue(op, a, b);
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== exp_r || out_flags !== exp_f || out_err !== 1'b0)
            $display("FAIL %s: got v=%b r=%h f=%b e=%b want v=1 r=%h f=%b e=0",
                     name, out_valid, out_result, out_flags, out_err, exp_r, exp_f);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_r, input logic [3:0] exp_f);
        int  edges;
        bit  ready_leak;
        ready_leak = 1'b0;
        issue(ALU_OP_MUL, a, b);
        edges = 1;
        while (!out_valid && edges < 100) begin
            if (in_ready !== 1'b0) ready_leak = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        total_cnt++;
        if (edges !== 33) $display("FAIL %s_latency: got %0d edges want 33", name, edges);
        else pass_cnt++;
        total_cnt++;
        if (ready_leak) $display("FAIL %s_in_ready: got 1 during iterations want 0", name);
        else pass_cnt++;
        total_cnt++;
        if (out_result !== exp_r || out_flags !== exp_f)
            $display("FAIL %s_result: got r=%h f=%b want r=%h f=%b", name, out_result, out_flags, exp_r, exp_f);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_back_to_back();
        bit unstable;
        bit ready_leak;
        unstable   = 1'b0;
        ready_leak = 1'b0;
        issue(ALU_OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00);
        // Producer holds the next op while the consumer stalls.
        in_op    = ALU_OP_AND;
        in_a     = 32'hF0F0F0F0;
        in_b     = 32'hFF00FF00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_result !== 32'h0FF00FF0 || out_flags !== 4'b0000) unstable = 1'b1;
            if (in_ready !== 1'b0) ready_leak = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (unstable) $display("FAIL hold_stable: got r=%h v=%b want r=0ff00ff0 v=1", out_result, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (ready_leak) $display("FAIL hold_in_ready: got 1 want 0");
        else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== 32'hF000F000)
            $display("FAIL stream_and: got v=%b r=%h want v=1 r=f000f000", out_valid, out_result);
        else pass_cnt++;
        in_op = ALU_OP_ORR;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== 32'hFFF0FFF0)
            $display("FAIL stream_orr: got v=%b r=%h want v=1 r=fff0fff0", out_valid, out_result);
        else pass_cnt++;
        in_op = ALU_OP_XOR;
        in_a  = 32'h12345678;
        in_b  = 32'h12345678;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== 32'h0 || out_flags !== 4'b0001)
            $display("FAIL stream_xor: got v=%b r=%h f=%b want v=1 r=0 f=0001", out_valid, out_result, out_flags);
        else pass_cnt++;
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stream_idle: got v=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        seen = 1'b0;
        issue(ALU_OP_MUL, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL midmul_reset: got v=%b rdy=%b want 0/0", out_valid, in_ready);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_result !== 32'h0)
            $display("FAIL midmul_idle: got rdy=%b r=%h want 1/0", in_ready, out_result);
        else pass_cnt++;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (seen) $display("FAIL midmul_no_emit: got out_valid pulse want none");
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        issue(4'd13, 32'h5, 32'h7);
        total_cnt++;
        if (out_valid !== 1'b1 || out_result !== 32'h0 || out_flags !== 4'b0000 || out_err !== 1'b1)
            $display("FAIL illegal_op: got v=%b r=%h f=%b e=%b want 1/0/0000/1",
                     out_valid, out_result, out_flags, out_err);
        else pass_cnt++;
        drain();
        total_cnt++;
        if (out_err !== 1'b1) $display("FAIL illegal_err_sticky: got %b want 1", out_err);
        else pass_cnt++;
        issue(ALU_OP_ADD, 32'd2, 32'd3);
        total_cnt++;
        if (out_err !== 1'b0 || out_result !== 32'd5 || out_flags !== 4'b0000)
            $display("FAIL illegal_err_clear: got e=%b r=%h f=%b want 0/5/0000", out_err, out_result, out_flags);
        else pass_cnt++;
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_single("add_carry",  ALU_OP_ADD, 32'hFFFFFFFF, 32'h1,        32'h00000000, 4'b0101);
        test_single("add_ovf",    ALU_OP_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1010);
        test_single("sub_borrow", ALU_OP_SUB, 32'h3,        32'h5,        32'hFFFFFFFE, 4'b0110);
        test_single("sra",        ALU_OP_SRA, 32'h80000000, 32'h00000104, 32'hF8000000, 4'b0010);
        test_single("shr",        ALU_OP_SHR, 32'h80000000, 32'h00000104, 32'h08000000, 4'b0000);
        test_single("shl_mask",   ALU_OP_SHL, 32'h1,        32'hFFFFFFE3, 32'h00000008, 4'b0000);
        test_single("shl_zero",   ALU_OP_SHL, 32'h0000ABCD, 32'h00000020, 32'h0000ABCD, 4'b0000);
        test_single("thb",        ALU_OP_THB, 32'h1,        32'h80000001, 32'h80000001, 4'b0010);
        test_mul("mul_hi",  32'h00010000, 32'h00010000, 32'h00000000, 4'b0101);
        test_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0100);
        test_mul("mul_low", 32'h00012345, 32'h00000100, 32'h01234500, 4'b0000);
        test_back_to_back();
        test_reset_mid_mul();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
